// File: rtl/vga_frame_checker_if.sv
// Pixel stream, expected-data handshake and result bus of the VGA frame checker.
// The bench or VGA unit drives through master; the checker sits on slave.
interface vga_frame_checker_if #(
  parameter int NUM_CH    = 3,
  parameter int CH_WIDTH  = 10,
  parameter int EXP_WIDTH = 8
);
  logic                          Start_i;
  logic                          Vsync_n_i;
  logic                          Pixel_valid_i;
  logic [9:0]                    Pixel_X_i;
  logic [9:0]                    Pixel_Y_i;
  logic [NUM_CH*CH_WIDTH-1:0]    Pixel_data_i;
  logic                          Exp_req_o;
  logic                          Exp_valid_i;
  logic [NUM_CH*EXP_WIDTH-1:0]   Exp_data_i;
  logic                          Busy_o;
  logic                          Done_o;
  logic                          Pass_o;
  logic                          Abort_o;
  logic                          Underrun_o;
  logic [15:0]                   Mismatch_cnt_o;
  logic [17:0]                   Pixel_cnt_o;
  logic [9:0]                    First_x_o;
  logic [9:0]                    First_y_o;
  logic [NUM_CH-1:0]             First_ch_o;

  modport master (
    output Start_i, Vsync_n_i, Pixel_valid_i, Pixel_X_i, Pixel_Y_i, Pixel_data_i,
    output Exp_valid_i, Exp_data_i,
    input  Exp_req_o, Busy_o, Done_o, Pass_o, Abort_o, Underrun_o,
    input  Mismatch_cnt_o, Pixel_cnt_o, First_x_o, First_y_o, First_ch_o
  );

  modport slave (
    input  Start_i, Vsync_n_i, Pixel_valid_i, Pixel_X_i, Pixel_Y_i, Pixel_data_i,
    input  Exp_valid_i, Exp_data_i,
    output Exp_req_o, Busy_o, Done_o, Pass_o, Abort_o, Underrun_o,
    output Mismatch_cnt_o, Pixel_cnt_o, First_x_o, First_y_o, First_ch_o
  );
endinterface

// File: rtl/vga_frame_checker.sv
// Hardware self-checker for one displayed VGA frame: compares window pixels against a
// prefetched expected RGB stream and reports mismatch counts and the first bad pixel.
module vga_frame_checker #(
  parameter int H_LEFT         = 160,
  parameter int H_RIGHT        = 480,
  parameter int V_TOP          = 120,
  parameter int V_BOTTOM       = 360,
  parameter int NUM_CH         = 3,
  parameter int CH_WIDTH       = 10,
  parameter int EXP_WIDTH      = 8,
  parameter int TOLERANCE      = 0,
  parameter int MAX_MISMATCHES = 10,
  parameter int FIFO_DEPTH     = 4
) (
  input logic                Clock_50,
  input logic                Reset,
  vga_frame_checker_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = NUM_CH * CH_WIDTH;
  localparam int EW = NUM_CH * EXP_WIDTH;

  localparam logic [9:0]          X_LO     = 10'(H_LEFT);
  localparam logic [9:0]          X_HI     = 10'(H_RIGHT);
  localparam logic [9:0]          Y_LO     = 10'(V_TOP);
  localparam logic [9:0]          Y_HI     = 10'(V_BOTTOM);
  localparam logic [17:0]         FULL_CNT = 18'((H_RIGHT - H_LEFT) * (V_BOTTOM - V_TOP));
  localparam logic [15:0]         MAX_MM   = 16'(MAX_MISMATCHES);
  localparam logic [CH_WIDTH:0]   TOL      = (CH_WIDTH + 1)'(TOLERANCE);
  localparam logic [PW:0]         DEPTH_C  = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW+1:0]       DEPTH_W  = (PW + 2)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CHECK,
    S_DONE,
    S_ABORT
  } state_t;

  state_t            state;
  logic              vs_q;

  logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       fifo_cnt;
  logic [PW:0]       outstanding;

  logic              cmp_valid;
  logic [NUM_CH-1:0] cmp_flags;
  logic [9:0]        cmp_x;
  logic [9:0]        cmp_y;

  logic [15:0]       mm_cnt;
  logic [17:0]       px_cnt;
  logic              underrun;
  logic [9:0]        first_x;
  logic [9:0]        first_y;
  logic [NUM_CH-1:0] first_ch;

  logic              active;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PW+1:0]     fill;
  logic              req;
  logic              in_window;
  logic              vsync_fall;
  logic              hit;
  logic              pop;
  logic              push_req;
  logic              push;
  logic              underrun_set;
  logic              start_arm;
  logic              resp_dec;
  logic [EW-1:0]     fifo_head;
  logic [NUM_CH-1:0] ch_miss;
  logic [15:0]       miss_pop;
  logic [16:0]       mm_sum;
  logic [15:0]       mm_next;

  assign active     = (state == S_ARM) || (state == S_CHECK);
  assign fifo_full  = (fifo_cnt == DEPTH_C);
  assign fifo_empty = (fifo_cnt == '0);
  // In-flight requests count against capacity so a late response never overflows.
  assign fill       = {1'b0, fifo_cnt} + {1'b0, outstanding};
  assign req        = active && (fill < DEPTH_W);

  assign in_window  = (bus.Pixel_X_i >= X_LO) && (bus.Pixel_X_i < X_HI) &&
                      (bus.Pixel_Y_i >= Y_LO) && (bus.Pixel_Y_i < Y_HI);
  assign vsync_fall = vs_q && !bus.Vsync_n_i;
  assign hit        = (state == S_CHECK) && bus.Pixel_valid_i && in_window && !vsync_fall;
  assign pop        = hit && !fifo_empty;

  assign push_req     = active && bus.Exp_valid_i;
  assign push         = push_req && (!fifo_full || pop);
  assign underrun_set = (hit && fifo_empty) || (push_req && fifo_full && !pop);
  assign resp_dec     = push_req && (outstanding != '0);

  assign start_arm = bus.Start_i &&
                     ((state == S_IDLE) || (state == S_DONE) || (state == S_ABORT));

  assign fifo_head = fifo_mem[rd_ptr];

  // Expected channel is left-aligned to the DAC width before the unsigned compare.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CH_WIDTH-1:0] got_v;
    logic [CH_WIDTH-1:0] exp_v;
    logic [CH_WIDTH:0]   diff;
    logic [CH_WIDTH:0]   mag;
    assign got_v = bus.Pixel_data_i[DW-1-c*CH_WIDTH -: CH_WIDTH];
    assign exp_v = CH_WIDTH'(fifo_head[EW-1-c*EXP_WIDTH -: EXP_WIDTH]) << (CH_WIDTH - EXP_WIDTH);
    assign diff  = {1'b0, got_v} - {1'b0, exp_v};
    assign mag   = diff[CH_WIDTH] ? -diff : diff;
    assign ch_miss[NUM_CH-1-c] = (mag > TOL);
  end

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    miss_pop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      miss_pop = miss_pop + 16'(cmp_flags[c]);
    end
  end

  assign mm_sum  = {1'b0, mm_cnt} + {1'b0, miss_pop};
  assign mm_next = !cmp_valid ? mm_cnt : (mm_sum[16] ? 16'hFFFF : mm_sum[15:0]);

  // NOTE: the FIFO storage has no reset; pointers and count define what is valid.
  always_ff @(posedge Clock_50) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.Exp_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state       <= S_IDLE;
      vs_q        <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
      cmp_valid   <= 1'b0;
      cmp_flags   <= '0;
      cmp_x       <= '0;
      cmp_y       <= '0;
      mm_cnt      <= '0;
      px_cnt      <= '0;
      underrun    <= 1'b0;
      first_x     <= '0;
      first_y     <= '0;
      first_ch    <= '0;
    end else begin
      vs_q <= bus.Vsync_n_i;
      if (start_arm) begin
        state       <= S_ARM;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        fifo_cnt    <= '0;
        outstanding <= '0;
        cmp_valid   <= 1'b0;
        cmp_flags   <= '0;
        mm_cnt      <= '0;
        px_cnt      <= '0;
        underrun    <= 1'b0;
        first_x     <= '0;
        first_y     <= '0;
        first_ch    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
          2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
          default: fifo_cnt <= fifo_cnt;
        endcase
        outstanding <= outstanding + (PW + 1)'(req) - (PW + 1)'(resp_dec);

        cmp_valid <= pop;
        if (pop) begin
          cmp_flags <= ch_miss;
          cmp_x     <= bus.Pixel_X_i;
          cmp_y     <= bus.Pixel_Y_i;
        end

        if (cmp_valid) begin
          px_cnt <= px_cnt + 1'b1;
          mm_cnt <= mm_next;
          if ((|cmp_flags) && (mm_cnt == '0)) begin
            first_x  <= cmp_x;
            first_y  <= cmp_y;
            first_ch <= cmp_flags;
          end
        end

        underrun <= underrun | underrun_set;

        case (state)
          S_ARM: begin
            if (!bus.Vsync_n_i) state <= S_CHECK;
          end
          S_CHECK: begin
            if (underrun || underrun_set || (mm_next > MAX_MM)) state <= S_ABORT;
            else if (vsync_fall)                                state <= S_DONE;
          end
          default: state <= state;
        endcase
      end
    end
  end

  assign bus.Exp_req_o      = req;
  assign bus.Busy_o         = active;
  assign bus.Done_o         = (state == S_DONE);
  assign bus.Abort_o        = (state == S_ABORT);
  assign bus.Pass_o         = (state == S_DONE) && (mm_cnt == '0) && !underrun &&
                              (px_cnt == FULL_CNT);
  assign bus.Underrun_o     = underrun;
  assign bus.Mismatch_cnt_o = mm_cnt;
  assign bus.Pixel_cnt_o    = px_cnt;
  assign bus.First_x_o      = first_x;
  assign bus.First_y_o      = first_y;
  assign bus.First_ch_o     = first_ch;

endmodule

// File: tb/tb_vga_frame_checker.sv
// Bench for vga_frame_checker on a shrunken 16x8 frame with an 8x4 window: table of frame
// scenarios, a per-pixel count scoreboard, and hand-written mid-frame reset sequence.
module tb_vga_frame_checker;

  localparam int HL = 4, HR = 12, VT = 2, VB = 6;
  localparam int NCH = 3, CW = 10, EW = 8, TOL = 3, MAXM = 10, DEPTH = 4;
  localparam int FW = 16, FH = 8;
  localparam int NPIX = (HR - HL) * (VB - VT);

  typedef enum int {M_EXACT, M_FIRST, M_TOL3, M_TOL4, M_EDGE_OUT, M_EDGE_IN} mode_t;

  typedef struct {
    string       name;
    mode_t       mode;
    int          supply;
    bit          start_mid;
    bit          e_done, e_pass, e_abort, e_under;
    int          e_px, e_mm, e_fx, e_fy;
    logic [2:0]  e_ch;
  } vec_t;

  typedef struct {
    int px;
    int mm;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   pend;
  bit   src_en = 1'b0;
  logic [23:0] exp_q [$];
  sb_t  sb_q [$];
  int   last_px;
  vec_t vecs [$];

  always #5 clk = ~clk;

  vga_frame_checker_if #(.NUM_CH(NCH), .CH_WIDTH(CW), .EXP_WIDTH(EW)) bus ();

  vga_frame_checker #(
    .H_LEFT(HL), .H_RIGHT(HR), .V_TOP(VT), .V_BOTTOM(VB),
    .NUM_CH(NCH), .CH_WIDTH(CW), .EXP_WIDTH(EW), .TOLERANCE(TOL),
    .MAX_MISMATCHES(MAXM), .FIFO_DEPTH(DEPTH)
  ) dut (
    .Clock_50 (clk),
    .Reset    (rst),
    .bus      (bus)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic vec_t mk(string n, mode_t m, int sup, bit sm, bit d, bit p, bit a,
                              bit u, int px, int mm, int fx, int fy, logic [2:0] ch);
    vec_t v;
    v.name = n; v.mode = m; v.supply = sup; v.start_mid = sm;
    v.e_done = d; v.e_pass = p; v.e_abort = a; v.e_under = u;
    v.e_px = px; v.e_mm = mm; v.e_fx = fx; v.e_fy = fy; v.e_ch = ch;
    return v;
  endfunction

  function automatic logic [29:0] make_got(mode_t m, int x, int y, logic [23:0] e);
    logic [9:0] ch [3];
    for (int c = 0; c < 3; c++) ch[c] = {e[23-8*c -: 8], 2'b00};
    case (m)
      M_FIRST: begin
        if (x == 5 && y == 3) ch[1] = ch[1] ^ 10'h200;
        else if (x == 9 && y == 4) for (int c = 0; c < 3; c++) ch[c] = ch[c] ^ 10'h200;
      end
      M_TOL3: ch[0] = ch[0] + 10'd3;
      M_TOL4: ch[0] = ch[0] + 10'd4;
      M_EDGE_OUT: begin
        if (x == HL - 1 || x == HR || y == VT - 1 || y == VB)
          for (int c = 0; c < 3; c++) ch[c] = ch[c] ^ 10'h200;
      end
      M_EDGE_IN: if (x == HR - 1 && y == VB - 1) ch[0] = ch[0] ^ 10'h200;
      default: ;
    endcase
    return {ch[0], ch[1], ch[2]};
  endfunction

  function automatic int miss_count(logic [29:0] got, logic [23:0] e);
    int n = 0;
    for (int c = 0; c < 3; c++) begin
      int d;
      d = int'(got[29-10*c -: 10]) - 4 * int'(e[23-8*c -: 8]);
      if (d < 0) d = -d;
      if (d > TOL) n++;
    end
    return n;
  endfunction

  // Expected-data source: answers each request after one or more cycles.
  initial begin
    bus.Exp_valid_i = 1'b0;
    bus.Exp_data_i  = '0;
    pend = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!src_en || rst) begin
        pend = 0;
        bus.Exp_valid_i = 1'b0;
      end else begin
        bus.Exp_valid_i = 1'b0;
        if (pend > 0 && exp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          bus.Exp_valid_i = 1'b1;
          bus.Exp_data_i  = exp_q.pop_front();
          pend--;
        end
        if (bus.Exp_req_o) pend++;
      end
    end
  end

  // Scoreboard: every pixel-count step must match the next predicted compare result.
  initial begin
    sb_t e;
    last_px = 0;
    forever begin
      @(negedge clk);
      if (int'(bus.Pixel_cnt_o) != last_px) begin
        if (bus.Pixel_cnt_o != '0) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra: got pixel_cnt=%0d want no compare", bus.Pixel_cnt_o);
          end else begin
            e = sb_q.pop_front();
            check("sb_px", 32'(bus.Pixel_cnt_o), e.px);
            check("sb_mm", 32'(bus.Mismatch_cnt_o), e.mm);
          end
        end
        last_px = int'(bus.Pixel_cnt_o);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic run_frame(input mode_t mode, input int supply, input bit start_mid,
                           input int reset_at);
    logic [23:0] mem [NPIX];
    logic [29:0] got;
    int idx, mm, px, n;
    bit dead, in_win;
    sb_t s;
    src_en = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    sb_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      mem[i] = {8'($urandom_range(0, 250)), 8'($urandom_range(0, 250)),
                8'($urandom_range(0, 250))};
      if (i < supply) exp_q.push_back(mem[i]);
    end
    bus.Start_i = 1'b1;
    src_en = 1'b1;
    @(negedge clk);
    bus.Start_i = 1'b0;
    repeat (6) @(negedge clk);
    bus.Vsync_n_i = 1'b0;
    repeat (3) @(negedge clk);
    bus.Vsync_n_i = 1'b1;
    repeat (4) @(negedge clk);
    idx = 0; mm = 0; px = 0; dead = 1'b0;
    for (int y = 0; y < FH; y++) begin
      for (int x = 0; x < FW; x++) begin
        in_win = (x >= HL) && (x < HR) && (y >= VT) && (y < VB);
        if (in_win && reset_at >= 0 && idx == reset_at) begin
          repeat (2) @(negedge clk);
          check("sb_pre_reset", sb_q.size(), 0);
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          sb_q.delete();
          return;
        end
        got = make_got(mode, x, y, in_win ? mem[idx] : 24'h5A3C71);
        bus.Pixel_valid_i = 1'b1;
        bus.Pixel_X_i     = 10'(x);
        bus.Pixel_Y_i     = 10'(y);
        bus.Pixel_data_i  = got;
        if (in_win) begin
          if (start_mid && idx == 3) bus.Start_i = 1'b1;
          if (!dead) begin
            if (idx >= supply) dead = 1'b1;
            else begin
              n = miss_count(got, mem[idx]);
              px++;
              mm += n;
              s.px = px;
              s.mm = mm;
              sb_q.push_back(s);
              if (mm > MAXM) dead = 1'b1;
            end
          end
          idx++;
        end
        @(negedge clk);
        bus.Pixel_valid_i = 1'b0;
        bus.Start_i = 1'b0;
        @(negedge clk);
      end
    end
    repeat (4) @(negedge clk);
    bus.Vsync_n_i = 1'b0;
    repeat (3) @(negedge clk);
    bus.Vsync_n_i = 1'b1;
    repeat (3) @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
  endtask

  task automatic check_final(input vec_t v);
    check({v.name, "_busy"},  32'(bus.Busy_o), 0);
    check({v.name, "_req"},   32'(bus.Exp_req_o), 0);
    check({v.name, "_done"},  32'(bus.Done_o), 32'(v.e_done));
    check({v.name, "_pass"},  32'(bus.Pass_o), 32'(v.e_pass));
    check({v.name, "_abort"}, 32'(bus.Abort_o), 32'(v.e_abort));
    check({v.name, "_under"}, 32'(bus.Underrun_o), 32'(v.e_under));
    check({v.name, "_px"},    32'(bus.Pixel_cnt_o), v.e_px);
    check({v.name, "_mm"},    32'(bus.Mismatch_cnt_o), v.e_mm);
    check({v.name, "_fx"},    32'(bus.First_x_o), v.e_fx);
    check({v.name, "_fy"},    32'(bus.First_y_o), v.e_fy);
    check({v.name, "_fch"},   32'(bus.First_ch_o), 32'(v.e_ch));
  endtask

  initial begin
    vec_t zero;
    bus.Start_i       = 1'b0;
    bus.Vsync_n_i     = 1'b1;
    bus.Pixel_valid_i = 1'b0;
    bus.Pixel_X_i     = '0;
    bus.Pixel_Y_i     = '0;
    bus.Pixel_data_i  = '0;

    //            name        mode        supply start done pass abrt undr px    mm  fx  fy  ch
    vecs.push_back(mk("exact",    M_EXACT,    NPIX, 0, 1, 1, 0, 0, NPIX, 0,  0,  0,  3'b000));
    vecs.push_back(mk("first",    M_FIRST,    NPIX, 1, 1, 0, 0, 0, NPIX, 4,  5,  3,  3'b010));
    vecs.push_back(mk("tol3",     M_TOL3,     NPIX, 0, 1, 1, 0, 0, NPIX, 0,  0,  0,  3'b000));
    vecs.push_back(mk("tol4",     M_TOL4,     NPIX, 0, 0, 0, 1, 0, 11,   11, 4,  2,  3'b100));
    vecs.push_back(mk("underrun", M_EXACT,    5,    0, 0, 0, 1, 1, 5,    0,  0,  0,  3'b000));
    vecs.push_back(mk("edge_out", M_EDGE_OUT, NPIX, 0, 1, 1, 0, 0, NPIX, 0,  0,  0,  3'b000));
    vecs.push_back(mk("edge_in",  M_EDGE_IN,  NPIX, 0, 1, 0, 0, 0, NPIX, 1,  11, 5,  3'b100));
    zero = mk("reset", M_EXACT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_final(zero);

    for (int i = 0; i < vecs.size(); i++) begin
      run_frame(vecs[i].mode, vecs[i].supply, vecs[i].start_mid, -1);
      check_final(vecs[i]);
    end

    // Reset one cycle mid-frame after two mismatches, then a clean frame from ARM.
    run_frame(M_FIRST, NPIX, 1'b0, 24);
    @(negedge clk);
    zero.name = "midrst";
    check_final(zero);
    run_frame(M_EXACT, NPIX, 1'b0, -1);
    vecs[0].name = "after_rst";
    check_final(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
